// File: rtl/wb_arbiter_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
// Grant encodings, entry layout and default sizing used by wb_arbiter and wb_fifo.
package wb_arbiter_pkg;

    localparam int unsigned RD_W    = 5;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ENTRY_W = RD_W + DATA_W;

    localparam int unsigned WB_DEFAULT_DEPTH        = 2;
    localparam int unsigned WB_DEFAULT_STARVE_LIMIT = 8;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_FIFO = 2'd2
    } wb_grant_e;

    typedef struct packed {
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // A source register conflicts only if it is a real (non-x0) register.
    function automatic logic rd_match(input logic [RD_W-1:0] i_rs,
                                      input logic [RD_W-1:0] i_rd);
        return (i_rs != '0) && (i_rs == i_rd);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO holding long-latency results {rd, data}.
// Exposes per-entry rd/valid so the arbiter can run its scoreboard lookup.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEFAULT_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_push_valid,
    output logic                          o_push_ready,
    input  wb_entry_t                     i_push_entry,
    input  logic                          i_pop,
    output wb_entry_t                     o_head,
    output logic                          o_empty,
    output logic [DEPTH-1:0]              o_entry_valid,
    output logic [DEPTH-1:0][RD_W-1:0]    o_entry_rd
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    wb_entry_t        r_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_push  = i_push_valid && !w_full;
    assign w_pop   = i_pop && !w_empty;

    // Pointers wrap naturally; count tracks occupancy including simultaneous push/pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    // Slot i is live when its distance from the read pointer is below the count.
    always_comb begin
        o_entry_valid = '0;
        o_entry_rd    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            o_entry_valid[i] = ({1'b0, PTR_W'(i) - r_rd_ptr} < r_count);
            o_entry_rd[i]    = r_mem[i].rd;
        end
    end

    assign o_head       = r_mem[r_rd_ptr];
    assign o_empty      = w_empty;
    assign o_push_ready = !w_full;

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: in-order writeback vs queued long-latency results.
// Optional starvation guard (counter + one-cycle pipeline stall) enabled by WB_STARVE_GUARD_EN.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH        = WB_DEFAULT_DEPTH,
    parameter int unsigned STARVE_LIMIT = WB_DEFAULT_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              p_we,
    input  logic [RD_W-1:0]   p_rd,
    input  logic [DATA_W-1:0] p_data,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [RD_W-1:0]   m_rd,
    input  logic [DATA_W-1:0] m_data,
    output logic              stall,
    input  logic [RD_W-1:0]   rs1,
    input  logic [RD_W-1:0]   rs2,
    output logic              busy1,
    output logic              busy2,
    output logic              rf_we,
    output logic [RD_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_param_check
        $error("wb_arbiter: DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
    end

    wb_entry_t                  w_push_entry;
    wb_entry_t                  w_head;
    logic                       w_push_valid;
    logic                       w_push_ready;
    logic                       w_pop;
    logic                       w_fifo_empty;
    logic [DEPTH-1:0]           w_entry_valid;
    logic [DEPTH-1:0][RD_W-1:0] w_entry_rd;

    logic      w_stall;
    logic      w_p_req;
    wb_grant_e w_grant;

    logic              r_rf_we;
    logic [RD_W-1:0]   r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;

    logic w_q_hit1;
    logic w_q_hit2;

    // x0 results complete the handshake but never occupy a slot.
    assign w_push_valid = m_valid && (m_rd != '0);
    assign w_push_entry = '{rd: m_rd, data: m_data};
    assign m_ready      = w_push_ready;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_push_valid  (w_push_valid),
        .o_push_ready  (w_push_ready),
        .i_push_entry  (w_push_entry),
        .i_pop         (w_pop),
        .o_head        (w_head),
        .o_empty       (w_fifo_empty),
        .o_entry_valid (w_entry_valid),
        .o_entry_rd    (w_entry_rd)
    );

    assign w_p_req = p_we && (p_rd != '0) && !w_stall;

    // Stall forces the queue head through; otherwise the pipeline has priority.
    always_comb begin
        w_grant = GNT_NONE;
        if (w_stall && !w_fifo_empty) begin
            w_grant = GNT_FIFO;
        end else if (w_p_req) begin
            w_grant = GNT_PIPE;
        end else if (!w_fifo_empty) begin
            w_grant = GNT_FIFO;
        end
    end

    assign w_pop = (w_grant == GNT_FIFO);

`ifdef WB_STARVE_GUARD_EN
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] r_starve_cnt;
    logic [STARVE_W-1:0] w_starve_cnt_nxt;
    logic                r_stall;

    // Counts cycles the head waits; saturates and clears once the head leaves.
    always_comb begin
        w_starve_cnt_nxt = r_starve_cnt;
        if (w_fifo_empty || (w_grant == GNT_FIFO)) begin
            w_starve_cnt_nxt = '0;
        end else if (r_starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
            w_starve_cnt_nxt = r_starve_cnt + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt <= '0;
            r_stall      <= 1'b0;
        end else begin
            r_starve_cnt <= w_starve_cnt_nxt;
            r_stall      <= (w_starve_cnt_nxt == STARVE_W'(STARVE_LIMIT));
        end
    end

    assign w_stall = r_stall;
`else
    assign w_stall = 1'b0;
`endif

    // Winner is registered onto the RF write port with one cycle of latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            case (w_grant)
                GNT_PIPE: begin
                    r_rf_we    <= 1'b1;
                    r_rf_waddr <= p_rd;
                    r_rf_wdata <= p_data;
                end
                GNT_FIFO: begin
                    r_rf_we    <= 1'b1;
                    r_rf_waddr <= w_head.rd;
                    r_rf_wdata <= w_head.data;
                end
                default: begin
                    r_rf_we    <= 1'b0;
                end
            endcase
        end
    end

    // Scoreboard: a source is busy while queued or sitting on the write port.
    always_comb begin
        w_q_hit1 = 1'b0;
        w_q_hit2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_entry_valid[i] && rd_match(rs1, w_entry_rd[i])) begin
                w_q_hit1 = 1'b1;
            end
            if (w_entry_valid[i] && rd_match(rs2, w_entry_rd[i])) begin
                w_q_hit2 = 1'b1;
            end
        end
    end

    assign busy1 = w_q_hit1 || (r_rf_we && rd_match(rs1, r_rf_waddr));
    assign busy2 = w_q_hit2 || (r_rf_we && rd_match(rs2, r_rf_waddr));

    assign stall    = w_stall;
    assign rf_we    = r_rf_we;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 8;
`ifdef WB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        p_we;
    logic [4:0]  p_rd;
    logic [31:0] p_data;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        stall;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        busy1;
    logic        busy2;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    wb_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .p_we     (p_we),
        .p_rd     (p_rd),
        .p_data   (p_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_rd     (m_rd),
        .m_data   (m_data),
        .stall    (stall),
        .rs1      (rs1),
        .rs2      (rs2),
        .busy1    (busy1),
        .busy2    (busy2),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_idle();
        p_we    = 1'b0;
        p_rd    = '0;
        p_data  = '0;
        m_valid = 1'b0;
        m_rd    = '0;
        m_data  = '0;
        rs1     = '0;
        rs2     = '0;
    endtask

    task automatic do_reset();
        set_idle();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mdl_q[$];
    int          mdl_cnt;
    bit          mdl_st;
    bit          mdl_we;
    logic [4:0]  mdl_waddr;
    logic [31:0] mdl_wdata;

    task automatic model_reset();
        mdl_q.delete();
        mdl_cnt   = 0;
        mdl_st    = 1'b0;
        mdl_we    = 1'b0;
        mdl_waddr = '0;
        mdl_wdata = '0;
    endtask

    function automatic bit mdl_busy(input logic [4:0] rs);
        if (rs == 5'd0) return 1'b0;
        foreach (mdl_q[i]) if (mdl_q[i].rd == rs) return 1'b1;
        return mdl_we && (mdl_waddr == rs);
    endfunction

    // Advance the model across one rising edge using the currently applied inputs.
    task automatic model_edge();
        int   sz;
        int   who;
        bit   pr;
        bit   acc;
        ent_t e;
        sz  = mdl_q.size();
        pr  = p_we && (p_rd != 5'd0) && !mdl_st;
        acc = m_valid && (sz < DEPTH) && (m_rd != 5'd0);
        if (mdl_st && sz > 0) who = 2;
        else if (pr)          who = 1;
        else if (sz > 0)      who = 2;
        else                  who = 0;
        if (GUARD) begin
            if (sz == 0 || who == 2) mdl_cnt = 0;
            else if (mdl_cnt < LIMIT) mdl_cnt++;
            mdl_st = (mdl_cnt == LIMIT);
        end
        if (who == 1) begin
            mdl_we = 1'b1; mdl_waddr = p_rd; mdl_wdata = p_data;
        end else if (who == 2) begin
            e = mdl_q.pop_front();
            mdl_we = 1'b1; mdl_waddr = e.rd; mdl_wdata = e.data;
        end else begin
            mdl_we = 1'b0;
        end
        if (acc) begin
            e.rd = m_rd; e.data = m_data;
            mdl_q.push_back(e);
        end
    endtask

    task automatic model_check();
        chk("rnd.rf_we", rf_we, mdl_we);
        if (mdl_we) begin
            chk("rnd.rf_waddr", rf_waddr, mdl_waddr);
            chk("rnd.rf_wdata", rf_wdata, mdl_wdata);
        end
        chk("rnd.m_ready", m_ready, mdl_q.size() < DEPTH);
        chk("rnd.stall", stall, mdl_st);
        chk("rnd.busy1", busy1, mdl_busy(rs1));
        chk("rnd.busy2", busy2, mdl_busy(rs2));
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        p_we;
        logic [4:0]  p_rd;
        logic [31:0] p_data;
        logic        m_valid;
        logic [4:0]  m_rd;
        logic [31:0] m_data;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic        e_ready;
        logic        e_busy1;
        logic        e_busy2;
    } vec_t;

    vec_t vt[10];

    int          pidx;
    logic [31:0] exp_data;

    initial begin
        set_idle();
        reset_n = 1'b0;
        tick();
        tick();
        chk("reset.rf_we", rf_we, 1'b0);
        chk("reset.rf_waddr", rf_waddr, 5'd0);
        chk("reset.rf_wdata", rf_wdata, 32'd0);
        chk("reset.stall", stall, 1'b0);
        chk("reset.m_ready", m_ready, 1'b1);
        reset_n = 1'b1;

        //          p_we  p_rd   p_data         m_v   m_rd   m_data     rs1    rs2    we    waddr  wdata          rdy   b1    b2
        vt[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0,  32'h0,    5'd5, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0};
        vt[1] = '{1'b1, 5'd0, 32'h11111111, 1'b0, 5'd0,  32'h0,    5'd5, 5'd0, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0};
        vt[2] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7,  32'h12,   5'd7, 5'd0, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 1'b0};
        vt[3] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,    5'd7, 5'd0, 1'b1, 5'd7, 32'h12,       1'b1, 1'b1, 1'b0};
        vt[4] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,    5'd7, 5'd0, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0};
        vt[5] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0,  32'h99,   5'd0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0};
        vt[6] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,    5'd0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0};
        vt[7] = '{1'b1, 5'd3, 32'hAAAA,     1'b1, 5'd9,  32'hBBBB, 5'd9, 5'd3, 1'b1, 5'd3, 32'hAAAA,     1'b1, 1'b1, 1'b1};
        vt[8] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,    5'd9, 5'd3, 1'b1, 5'd9, 32'hBBBB,     1'b1, 1'b1, 1'b0};
        vt[9] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,    5'd9, 5'd3, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0};

        for (int i = 0; i < 10; i++) begin
            p_we = vt[i].p_we; p_rd = vt[i].p_rd; p_data = vt[i].p_data;
            m_valid = vt[i].m_valid; m_rd = vt[i].m_rd; m_data = vt[i].m_data;
            rs1 = vt[i].rs1; rs2 = vt[i].rs2;
            tick();
            #1;
            chk($sformatf("vec%0d.rf_we", i), rf_we, vt[i].e_we);
            if (vt[i].e_we) begin
                chk($sformatf("vec%0d.rf_waddr", i), rf_waddr, vt[i].e_waddr);
                chk($sformatf("vec%0d.rf_wdata", i), rf_wdata, vt[i].e_wdata);
            end
            chk($sformatf("vec%0d.m_ready", i), m_ready, vt[i].e_ready);
            chk($sformatf("vec%0d.busy1", i), busy1, vt[i].e_busy1);
            chk($sformatf("vec%0d.busy2", i), busy2, vt[i].e_busy2);
            chk($sformatf("vec%0d.stall", i), stall, 1'b0);
        end

        // Contention with a full FIFO, then reset while entries are queued.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            p_we = 1'b1; p_rd = 5'(c + 1); p_data = 32'(32'h100 + c);
            m_valid = (c < 3); m_rd = 5'(10 + c); m_data = 32'(32'h700 + c);
            rs1 = 5'd10; rs2 = 5'd12;
            #1;
            chk($sformatf("full.c%0d.m_ready", c), m_ready, c < 2);
            if (c >= 1) begin
                chk($sformatf("full.c%0d.rf_we", c), rf_we, 1'b1);
                chk($sformatf("full.c%0d.rf_waddr", c), rf_waddr, 5'(c));
                chk($sformatf("full.c%0d.rf_wdata", c), rf_wdata, 32'(32'h100 + c - 1));
                chk($sformatf("full.c%0d.busy1", c), busy1, 1'b1);
                chk($sformatf("full.c%0d.busy2", c), busy2, 1'b0);
            end
            tick();
        end
        rs1 = 5'd10; rs2 = 5'd11;
        #2;
        reset_n = 1'b0;
        #1;
        chk("rstmid.rf_we", rf_we, 1'b0);
        chk("rstmid.rf_waddr", rf_waddr, 5'd0);
        chk("rstmid.rf_wdata", rf_wdata, 32'd0);
        chk("rstmid.m_ready", m_ready, 1'b1);
        chk("rstmid.busy1", busy1, 1'b0);
        chk("rstmid.busy2", busy2, 1'b0);
        chk("rstmid.stall", stall, 1'b0);
        @(negedge clk);
        m_valid = 1'b0; p_we = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("rstmid.post%0d.rf_we", c), rf_we, 1'b0);
            chk($sformatf("rstmid.post%0d.busy1", c), busy1, 1'b0);
            tick();
        end

        // Starvation: one queued entry under continuous pipeline writes.
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            pidx = (GUARD && c >= 10) ? c - 1 : c;
            p_we = 1'b1; p_rd = 5'(pidx + 1); p_data = 32'(100 + pidx);
            m_valid = (c == 0); m_rd = 5'd20; m_data = 32'h5555;
            rs1 = 5'd20; rs2 = 5'd0;
            #1;
            chk($sformatf("starve.c%0d.stall", c), stall, GUARD && (c == 9));
            chk($sformatf("starve.c%0d.busy1", c), busy1,
                GUARD ? (c >= 1 && c <= 10) : (c >= 1));
            if (c >= 1) begin
                if (!GUARD || c <= 9) exp_data = 32'(100 + c - 1);
                else if (c == 10)     exp_data = 32'h5555;
                else                  exp_data = 32'(100 + c - 2);
                chk($sformatf("starve.c%0d.rf_we", c), rf_we, 1'b1);
                chk($sformatf("starve.c%0d.rf_wdata", c), rf_wdata, exp_data);
            end
            tick();
        end

        // Back-to-back enqueue/dequeue at occupancy one, wrapping the pointers.
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            m_valid = (c < 10); m_rd = 5'(c + 1); m_data = 32'(32'hA0 + c);
            rs1 = 5'(c); rs2 = 5'd0;
            #1;
            chk($sformatf("wrap.c%0d.m_ready", c), m_ready, 1'b1);
            chk($sformatf("wrap.c%0d.rf_we", c), rf_we, (c >= 2 && c <= 11));
            if (c >= 2 && c <= 11) begin
                chk($sformatf("wrap.c%0d.rf_waddr", c), rf_waddr, 5'(c - 1));
                chk($sformatf("wrap.c%0d.rf_wdata", c), rf_wdata, 32'(32'hA0 + c - 2));
            end
            if (c >= 1 && c <= 10) chk($sformatf("wrap.c%0d.busy1", c), busy1, 1'b1);
            tick();
        end

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            if (!mdl_st) begin
                p_we   = ($urandom_range(0, 9) < 7);
                p_rd   = 5'($urandom_range(0, 7));
                p_data = $urandom;
            end
            m_valid = ($urandom_range(0, 2) == 0);
            m_rd    = 5'($urandom_range(0, 7));
            m_data  = $urandom;
            rs1     = 5'($urandom_range(0, 7));
            rs2     = 5'($urandom_range(0, 7));
            #1;
            model_check();
            @(posedge clk);
            model_edge();
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
